dram_multibank: RTL

//  Cycle-approximate multi-bank DRAM model with per-bank open-row tracking, parametrised

---
 rtl/dram_multibank_if.sv | 27 ++
 rtl/dram_multibank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dram_multibank_if.sv
// Request/burst channel between the memory controller and the multi-bank DRAM model.
interface dram_multibank_if #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned BURST_W = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADDR_W-1:0]  req_addr;
  logic [BURST_W-1:0] wdata;
  logic               wvalid;
  logic               wready;
  logic [BURST_W-1:0] rdata;
  logic               rvalid;
  logic               rlast;
  logic               done;

  modport master (
    output req_valid, req_we, req_addr, wdata, wvalid,
    input  req_ready, wready, rdata, rvalid, rlast, done
  );

  modport slave (
    input  req_valid, req_we, req_addr, wdata, wvalid,
    output req_ready, wready, rdata, rvalid, rlast, done
  );
endinterface

// File: rtl/dram_multibank.sv
// Cycle-approximate multi-bank DRAM with per-bank open-row tracking, one burst at a time,
// open-page policy and saturating row hit/miss counters.
module dram_multibank #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned NUM_ROWS  = 16,
  parameter int unsigned ROW_WIDTH = 256,
  parameter int unsigned BURST_W   = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned T_PRE     = 2,
  parameter int unsigned T_ACT     = 3,
  parameter int unsigned T_CAS     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dram_multibank_if.slave bus,
  output logic [31:0]     o_row_hit_cnt,
  output logic [31:0]     o_row_miss_cnt
);
  localparam int unsigned BANK_W    = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W     = $clog2(NUM_ROWS);
  localparam int unsigned NUM_COLS  = ROW_WIDTH / BURST_W;
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned ADDR_W    = ROW_W + BANK_W + COL_W;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned BEAT_W    = $clog2(BURST_LEN + 1);
  localparam int unsigned TMR_W     = 8;

  localparam logic [TMR_W-1:0]  PRE_LD   = TMR_W'(T_PRE - 1);
  localparam logic [TMR_W-1:0]  ACT_LD   = TMR_W'(T_ACT - 1);
  localparam logic [TMR_W-1:0]  CAS_LD   = TMR_W'(T_CAS - 1);
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LST = BEAT_W'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRECHARGE = 3'd1;
  localparam logic [2:0] S_ACTIVATE  = 3'd2;
  localparam logic [2:0] S_CAS       = 3'd3;
  localparam logic [2:0] S_READ      = 3'd4;
  localparam logic [2:0] S_WRITE     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]         r_state;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_we;
  logic [ROW_W-1:0]   r_row;
  logic [BANK_W-1:0]  r_bank;
  logic [COL_W-1:0]   r_col;
  logic [BEAT_W-1:0]  r_beat;
  logic [NUM_BANKS-1:0] r_open_vld;
  logic [ROW_W-1:0]   r_open_row [NUM_BANKS];
  logic [BURST_W-1:0] r_mem [MEM_DEPTH];
  logic [BURST_W-1:0] r_rdata;
  logic               r_rvalid;
  logic               r_rlast;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;

  logic               w_accept;
  logic [COL_W-1:0]   w_a_col;
  logic [BANK_W-1:0]  w_a_bank;
  logic [ROW_W-1:0]   w_a_row;
  logic               w_hit;
  logic               w_closed;
  logic [ADDR_W-1:0]  w_mem_idx;
  logic               w_wbeat;
  logic               w_rbeat;

  assign w_a_col   = bus.req_addr[COL_W-1:0];
  assign w_a_bank  = bus.req_addr[COL_W +: BANK_W];
  assign w_a_row   = bus.req_addr[COL_W+BANK_W +: ROW_W];
  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_closed  = !r_open_vld[w_a_bank];
  assign w_hit     = r_open_vld[w_a_bank] && (r_open_row[w_a_bank] == w_a_row);
  // Column field is COL_W wide, so incrementing it wraps within the row for free.
  assign w_mem_idx = {r_bank, r_row, r_col};
  assign w_wbeat   = (r_state == S_WRITE) && bus.wvalid;
  assign w_rbeat   = (r_state == S_READ) && (r_beat != BEAT_END);

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.wready     = (r_state == S_WRITE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.rdata      = r_rdata;
  assign bus.rvalid     = r_rvalid;
  assign bus.rlast      = r_rlast;
  assign o_row_hit_cnt  = r_hit_cnt;
  assign o_row_miss_cnt = r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wbeat) r_mem[w_mem_idx] <= bus.wdata;
      if (w_rbeat) r_rdata <= r_mem[w_mem_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_we       <= 1'b0;
      r_row      <= '0;
      r_bank     <= '0;
      r_col      <= '0;
      r_beat     <= '0;
      r_open_vld <= '0;
      for (int b = 0; b < int'(NUM_BANKS); b++) r_open_row[b] <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= bus.req_we;
            r_row  <= w_a_row;
            r_bank <= w_a_bank;
            r_col  <= w_a_col;
            if (w_hit) begin
              r_state <= S_CAS;
              r_tmr   <= CAS_LD;
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
              r_state <= w_closed ? S_ACTIVATE : S_PRECHARGE;
              r_tmr   <= w_closed ? ACT_LD : PRE_LD;
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
          end
        end
        S_PRECHARGE: begin
          if (r_tmr == '0) begin
            r_state            <= S_ACTIVATE;
            r_tmr              <= ACT_LD;
            r_open_vld[r_bank] <= 1'b0;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_ACTIVATE: begin
          if (r_tmr == '0) begin
            r_state            <= S_CAS;
            r_tmr              <= CAS_LD;
            r_open_vld[r_bank] <= 1'b1;
            r_open_row[r_bank] <= r_row;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_CAS: begin
          if (r_tmr == '0) begin
            r_state <= r_we ? S_WRITE : S_READ;
            r_beat  <= '0;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_READ: begin
          // One extra cycle after the last beat so done follows rlast.
          if (r_beat == BEAT_END) begin
            r_state <= S_DONE;
          end else begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_beat == BEAT_LST);
            r_beat   <= r_beat + BEAT_W'(1);
            r_col    <= r_col + COL_W'(1);
          end
        end
        S_WRITE: begin
          if (bus.wvalid) begin
            r_beat <= r_beat + BEAT_W'(1);
            r_col  <= r_col + COL_W'(1);
            if (r_beat == BEAT_LST) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
